// File: rtl/rob_marker_tracker.sv
// Scans ROB commit slots for `slti x0,x0,K` phase markers, tracks the testcase phase and
// queues timestamped marker events to the logger. Optional macro: MARKER_TAINT_SNAPSHOT_EN.
module rob_marker_tracker #(
  parameter int COMMIT_WIDTH = 2,
  parameter int TS_W         = 40,
  parameter int FIFO_DEPTH   = 8,
  parameter int TAINT_W      = 32,
  localparam int SLOT_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COMMIT_WIDTH-1:0]   commit_valid,
  input  logic [32*COMMIT_WIDTH-1:0] commit_inst,
  // Event port: ev_valid means the head entry is valid; it transfers on a cycle with
  // ev_valid && ev_ready, and the ev_* fields hold stable while ev_valid && !ev_ready.
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [3:0]                ev_kind,
  output logic [SLOT_W-1:0]         ev_slot,
  output logic [TS_W-1:0]           ev_time,
`ifdef MARKER_TAINT_SNAPSHOT_EN
  input  logic [TAINT_W-1:0]        taint_sum,
  output logic [TAINT_W-1:0]        ev_taint,
`endif
  output logic [2:0]                phase,
  output logic [31:0]               phase_cycles,
  output logic [31:0]               last_phase_len,
  output logic                      victim_done,
  output logic                      seq_error,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef MARKER_TAINT_SNAPSHOT_EN
  localparam int ENT_W = 4 + SLOT_W + TS_W + TAINT_W;
`else
  localparam int ENT_W = 4 + SLOT_W + TS_W;
`endif
  localparam logic [2:0] PH_NONE = 3'd7;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [2:0]       phase_q, phase_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      lpl_q, lpl_d;
  logic             vd_q, vd_d;
  logic             se_q, se_d;
  logic [15:0]      drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];

  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] n_push;
  logic             touched;
  logic             pop;
  logic [31:0]      inst;
  logic [3:0]       kind;
  logic [2:0]       pid;
  logic [PTR_W-1:0] wr_idx;
  logic [ENT_W-1:0] head;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    phase_d    = phase_q;
    pc_d       = pc_q;
    lpl_d      = lpl_q;
    vd_d       = vd_q;
    se_d       = se_q;
    drop_d     = drop_q;
    mem_d      = mem_q;
    free_slots = CNT_W'(FIFO_DEPTH) - count_q;
    n_push     = '0;
    touched    = 1'b0;
    inst       = '0;
    kind       = '0;
    pid        = '0;
    wr_idx     = '0;

    // Slots are handled oldest first; each one sees the phase left by the previous slot.
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      inst = commit_inst[32*i +: 32];
      if (commit_valid[i] && inst[19:0] == 20'h02013 && inst[31:20] <= 12'd13) begin
        kind = inst[23:20];
        pid  = kind[3:1];
        if (!kind[0]) begin
          se_d    = se_d | (phase_d != PH_NONE);
          phase_d = pid;
          pc_d    = '0;
          touched = 1'b1;
        end else if (phase_d == pid) begin
          lpl_d   = pc_d;
          vd_d    = vd_d | (pid == 3'd0);
          phase_d = PH_NONE;
          pc_d    = '0;
          touched = 1'b1;
        end else begin
          se_d = 1'b1;
        end

        // Space is judged from start-of-cycle occupancy; a concurrent pop does not help.
        if (n_push < free_slots) begin
          wr_idx = wr_ptr_q + n_push[PTR_W-1:0];
`ifdef MARKER_TAINT_SNAPSHOT_EN
          mem_d[wr_idx] = {kind, SLOT_W'(i), ts_q, taint_sum};
`else
          mem_d[wr_idx] = {kind, SLOT_W'(i), ts_q};
`endif
          n_push = n_push + CNT_W'(1);
        end else if (drop_d != 16'hFFFF) begin
          drop_d = drop_d + 16'd1;
        end
      end
    end

    if (!touched && phase_q != PH_NONE && pc_q != 32'hFFFF_FFFF) begin
      pc_d = pc_q + 32'd1;
    end

    pop      = (count_q != '0) && ev_ready;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + n_push[PTR_W-1:0];
    count_d  = count_q + n_push - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q     <= '0;
      phase_q  <= PH_NONE;
      pc_q     <= '0;
      lpl_q    <= '0;
      vd_q     <= 1'b0;
      se_q     <= 1'b0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      ts_q     <= ts_d;
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      lpl_q    <= lpl_d;
      vd_q     <= vd_d;
      se_q     <= se_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign ev_valid       = (count_q != '0);
  assign ev_kind        = head[ENT_W-1 -: 4];
  assign ev_slot        = head[ENT_W-5 -: SLOT_W];
  assign ev_time        = head[ENT_W-5-SLOT_W -: TS_W];
`ifdef MARKER_TAINT_SNAPSHOT_EN
  assign ev_taint       = head[TAINT_W-1:0];
`endif
  assign phase          = phase_q;
  assign phase_cycles   = pc_q;
  assign last_phase_len = lpl_q;
  assign victim_done    = vd_q;
  assign seq_error      = se_q;
  assign drop_count     = drop_q;

endmodule
